// File: rtl/ram_ring_capture.sv
// Multi-channel triggered capture buffer: records NCH channels into a circular
// block-RAM window, freezes it a programmable number of samples after a trigger.
module ram_ring_capture #(
    parameter int NCH       = 2,
    parameter int SIGSIZE   = 16,
    parameter int ADDRWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NCH*SIGSIZE-1:0]   in,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [ADDRWIDTH-1:0]     post_len,
    input  logic                     rd_en,
    input  logic [ADDRWIDTH-1:0]     rd_addr,
    output logic [NCH*SIGSIZE-1:0]   rd_data,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic [ADDRWIDTH-1:0]     trig_ptr,
    output logic [ADDRWIDTH:0]       valid_cnt
);

    localparam int MEMSIZE = 2 ** ADDRWIDTH;
    localparam int W       = NCH * SIGSIZE;
    localparam logic [ADDRWIDTH-1:0] ONE  = ADDRWIDTH'(1);
    localparam logic [ADDRWIDTH:0]   FULL = (ADDRWIDTH + 1)'(MEMSIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 cur_state;
    logic [ADDRWIDTH-1:0]   wr_ptr;
    logic [ADDRWIDTH-1:0]   post_cnt;
    logic [ADDRWIDTH-1:0]   rd_addr_q;
    logic                   rd_pend;
    logic                   do_write;

    (* ram_style = "block" *) logic [W-1:0] mem [MEMSIZE] = '{default: '0};

    assign state    = cur_state;
    assign do_write = in_valid && ((cur_state == ARMED) || (cur_state == POST));

    // Storage has no reset so a capture survives rst for later inspection.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= in;
        end
    end

    // Two-stage read: window offset -> physical address, then registered RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_pend   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_pend  <= rd_en;
            rd_valid <= rd_pend;
            if (rd_en) begin
                rd_addr_q <= wr_ptr + rd_addr;
            end
            if (rd_pend) begin
                rd_data <= mem[rd_addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            wr_ptr    <= '0;
            trig_ptr  <= '0;
            valid_cnt <= '0;
            post_cnt  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ONE;
                if (valid_cnt != FULL) begin
                    valid_cnt <= valid_cnt + 1'b1;
                end
            end
            case (cur_state)
                IDLE, DONE: begin
                    if (arm) begin
                        cur_state <= ARMED;
                        valid_cnt <= '0;
                    end
                end
                ARMED: begin
                    // post_len cannot exceed MEMSIZE-1 at this width, so no clamp logic is needed.
                    if (in_valid && trig) begin
                        trig_ptr  <= wr_ptr;
                        post_cnt  <= post_len;
                        cur_state <= (post_len == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (in_valid) begin
                        post_cnt <= post_cnt - ONE;
                        if (post_cnt == ONE) begin
                            cur_state <= DONE;
                        end
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ring_capture.sv
// Self-checking bench for ram_ring_capture: reference model of the capture FSM
// and memory, with a read scoreboard checking data order and 2-cycle latency.
module tb_ram_ring_capture;

    localparam int NCH = 2;
    localparam int SIGSIZE = 16;
    localparam int AW = 4;
    localparam int MS = 16;
    localparam int W = NCH * SIGSIZE;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          arm;
    logic          trig;
    logic [AW-1:0] post_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic [AW-1:0] trig_ptr;
    logic [AW:0]   valid_cnt;

    ram_ring_capture #(.NCH(NCH), .SIGSIZE(SIGSIZE), .ADDRWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_data), .arm(arm),
        .trig(trig), .post_len(post_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
        .trig_ptr(trig_ptr), .valid_cnt(valid_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit drop_reads = 0;

    logic [W-1:0] m_mem [MS];
    int m_state, m_wp, m_tp, m_vc, m_pc;

    logic [W-1:0] exp_q [$];
    int           due_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k);
        return {16'(256 + k), 16'(k)};
    endfunction

    // Reference behaviour of one clock edge.
    task automatic modelEdge(input logic r, input logic iv, input logic [W-1:0] d,
                             input logic a, input logic t, input logic [AW-1:0] pl);
        if (r) begin
            m_state = 0; m_wp = 0; m_tp = 0; m_vc = 0; m_pc = 0;
        end else begin
            case (m_state)
                0, 3: if (a) begin m_state = 1; m_vc = 0; end
                1: if (iv) begin
                    m_mem[m_wp] = d;
                    if (t) begin
                        m_tp = m_wp;
                        m_pc = int'(pl);
                        m_state = (pl == 0) ? 3 : 2;
                    end
                    m_wp = (m_wp + 1) % MS;
                    if (m_vc < MS) m_vc++;
                end
                2: if (iv) begin
                    m_mem[m_wp] = d;
                    m_wp = (m_wp + 1) % MS;
                    if (m_vc < MS) m_vc++;
                    if (m_pc == 1) m_state = 3;
                    m_pc--;
                end
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [W-1:0] d,
                                 input logic a, input logic t, input logic [AW-1:0] pl,
                                 input logic re, input logic [AW-1:0] ra,
                                 input logic exp_given, input logic [W-1:0] exp_val);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; arm = a; trig = t; post_len = pl;
        rd_en = re; rd_addr = ra;
        if (re && !r && !drop_reads) begin
            exp_q.push_back(exp_given ? exp_val : m_mem[(m_wp + int'(ra)) % MS]);
            due_q.push_back(cyc + 2);
        end
        @(posedge clk);
        modelEdge(r, iv, d, a, t, pl);
        #1;
        checkOutput("state", 32'(state), 32'(m_state));
        checkOutput("trig_ptr", 32'(trig_ptr), 32'(m_tp));
        checkOutput("valid_cnt", 32'(valid_cnt), 32'(m_vc));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic sample(input int k, input logic t, input logic [AW-1:0] pl);
        applyStimulus(0, 1, mk(k), 0, t, pl, 0, '0, 0, '0);
    endtask

    task automatic readExpect(input logic [AW-1:0] ra, input logic [W-1:0] e);
        applyStimulus(0, 0, '0, 0, 0, '0, 1, ra, 1, e);
    endtask

    task automatic drainReads();
        int n = 0;
        while (exp_q.size() != 0 && n < 8) begin
            idleCycles(1);
            n++;
        end
        checkOutput("rd_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic readAll();
        for (int off = 0; off < MS; off++) applyStimulus(0, 0, '0, 0, 0, '0, 1, AW'(off), 0, '0);
        drainReads();
    endtask

    task automatic streamUntilDone(input int tk, input logic [AW-1:0] pl, input bit arm_in_post);
        int k = 0;
        bit arm_sent = 0;
        while (m_state != 3 && k < 40) begin
            if (arm_in_post && m_state == 2 && !arm_sent) begin
                applyStimulus(0, 0, '0, 1, 0, pl, 0, '0, 0, '0);
                arm_sent = 1;
            end
            sample(k, k == tk, pl);
            k++;
        end
        checkOutput("done_reached", 32'(state), 32'd3);
        sample(k, 0, pl);
    endtask

    // Read scoreboard: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("rd_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("rd_data", rd_data, exp_q.pop_front());
                checkOutput("rd_latency", 32'(cyc), 32'(due_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < MS; i++) m_mem[i] = '0;
        rst = 1; in_valid = 0; in_data = '0; arm = 0; trig = 0; post_len = '0;
        rd_en = 0; rd_addr = '0;

        applyStimulus(1, 0, '0, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0, 0, '0, 0, '0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);

        $display("[TB] trig in IDLE ignored");
        applyStimulus(0, 1, mk(99), 0, 1, 4'd3, 0, '0, 0, '0);

        $display("[TB] capture A: trig k=5 post 3");
        applyStimulus(0, 0, '0, 1, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 0, '0, 0, 1, 4'd3, 0, '0, 0, '0);
        streamUntilDone(5, 4'd3, 0);
        checkOutput("A_valid_cnt", 32'(valid_cnt), 32'd9);
        checkOutput("A_trig_ptr", 32'(trig_ptr), 32'd5);
        readAll();
        readExpect(4'd0, '0);
        readExpect(4'd7, mk(0));
        readExpect(4'd15, mk(8));
        drainReads();

        $display("[TB] capture B: trig k=20 post 3, arm in POST ignored");
        applyStimulus(1, 0, '0, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 0, '0, 1, 0, '0, 0, '0, 0, '0);
        streamUntilDone(20, 4'd3, 1);
        checkOutput("B_valid_cnt", 32'(valid_cnt), 32'd16);
        checkOutput("B_trig_ptr", 32'(trig_ptr), 32'd4);
        readAll();
        readExpect(4'd12, mk(20));
        readExpect(4'd0, mk(8));
        drainReads();

        $display("[TB] capture C: arm+trig together, post 0");
        applyStimulus(0, 1, mk(50), 1, 1, '0, 0, '0, 0, '0);
        streamUntilDone(10, 4'd0, 0);
        readExpect(4'd15, mk(10));
        drainReads();

        $display("[TB] capture D: post 15");
        applyStimulus(0, 0, '0, 1, 0, '0, 0, '0, 0, '0);
        streamUntilDone(2, 4'd15, 0);
        checkOutput("D_valid_cnt_sat", 32'(valid_cnt), 32'd16);
        readExpect(4'd0, mk(2));
        readAll();

        $display("[TB] reset during POST");
        applyStimulus(0, 0, '0, 1, 0, '0, 0, '0, 0, '0);
        for (int k = 0; k < 6; k++) sample(k, k == 3, 4'd5);
        checkOutput("E_in_post", 32'(state), 32'd2);
        drop_reads = 1;
        applyStimulus(0, 0, '0, 0, 0, '0, 1, 4'd3, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0, 0, '0, 0, '0);
        drop_reads = 0;
        checkOutput("E_rst_state", 32'(state), 32'd0);
        checkOutput("E_rst_valid_cnt", 32'(valid_cnt), 32'd0);
        checkOutput("E_rst_rd_valid", 32'(rd_valid), 32'd0);
        idleCycles(3);
        applyStimulus(0, 0, '0, 1, 0, '0, 0, '0, 0, '0);
        streamUntilDone(4, 4'd2, 0);
        readAll();

        idleCycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_ring_capture.md
# ram_ring_capture

Multi-channel triggered capture buffer: the parametrised successor to the single-channel dual-port block RAM. Continuously records NCH parallel channels into a circular block-RAM window while armed, latches a trigger point, records a programmable number of post-trigger samples, then freezes the window for readout. Sits between the ADC/filter sample stream and the host readout/diagnostic logic.

## Interface
- NCH, 2, number of channels, all stored at one shared address
- SIGSIZE, 16, bits per channel sample
- ADDRWIDTH, 10, address width; depth MEMSIZE = 2**ADDRWIDTH
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe; one write per high cycle when recording
- in  in  NCH*SIGSIZE  channel c in bits [c*SIGSIZE +: SIGSIZE]
- arm  in  1  start recording (from IDLE or DONE)
- trig  in  1  trigger; qualified by in_valid
- post_len  in  ADDRWIDTH  post-trigger sample count, latched at trigger
- rd_en  in  1  read request
- rd_addr  in  ADDRWIDTH  window offset; 0 = oldest, MEMSIZE-1 = newest
- rd_data  out  NCH*SIGSIZE  read data
- rd_valid  out  1  rd_data valid strobe
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- trig_ptr  out  ADDRWIDTH  physical address of trigger sample
- valid_cnt  out  ADDRWIDTH+1  samples written since arm, saturates at MEMSIZE

## Operation
- Memory: one (* ram_style = "block" *) array MEMSIZE x NCH*SIGSIZE, zero-initialised at configuration, never cleared by rst. Read-first on same-address collision.
- IDLE: no writes. arm -> ARMED; valid_cnt <= 0; wr_ptr not reset.
- ARMED: each in_valid cycle writes in at wr_ptr, wr_ptr++ modulo MEMSIZE, valid_cnt++ saturating. trig && in_valid: that sample is the trigger sample; trig_ptr <= wr_ptr; post counter <= min(post_len, MEMSIZE-1); next state POST, or DONE if post_len == 0.
- POST: each in_valid cycle writes, advances, decrements counter; write with counter == 1 -> DONE. Exactly post_len samples follow the trigger sample.
- DONE: writes inhibited; wr_ptr frozen and points at oldest sample. arm -> ARMED (new capture). Trigger sample sits at rd_addr = MEMSIZE-1-post_len (clamped). Offsets below MEMSIZE-valid_cnt are stale data.
- Ignored events: trig without in_valid; trig in IDLE/POST/DONE; arm in ARMED/POST. arm and trig in same cycle from IDLE/DONE: arm taken, trig ignored.
- Readout: physical address = (wr_ptr + rd_addr) mod MEMSIZE, wrap by truncation. Reads are accepted in any state; content is only defined in DONE.

## Timing
- Read latency 2: cycle N rd_en/rd_addr sampled and physical address registered; N+1 memory read registered; rd_data/rd_valid valid in cycle N+2. rd_valid is a 1-cycle pulse per rd_en; back-to-back rd_en gives one result per cycle.
- Write: sample at in_valid edge N is stored at edge N; state/trig_ptr/valid_cnt update at the same edge.
- DONE entered on the edge of the last post-trigger write; a sample with in_valid in the next cycle is not stored.
- Reset (rst high at edge): state=IDLE, wr_ptr=0, trig_ptr=0, valid_cnt=0, post counter=0, rd_valid=0, rd_data=0; reads in flight are dropped. Mid-capture reset aborts, memory retains data.

## Test plan
- ADDRWIDTH=4, NCH=2: arm, stream ch0=k, ch1=0x100+k (k=0..), trig at k=20, post_len=3 -> DONE after k=23; read offsets 0..15 return k=8..23; trigger (k=20) at offset 12; trig_ptr=4; valid_cnt=16.
- Same, trig at k=5, post_len=3 -> valid_cnt=9; offsets 7..15 return k=0..8; offsets 0..6 zeros (stale/initial).
- post_len=0, trig at k=10 -> DONE on same edge; offset 15 returns k=10; post_len=15 clamps, trig at offset 0.
- trig with in_valid=0, trig in IDLE, arm during POST -> state unchanged; later qualified trig captures normally.
- rst asserted in POST -> next cycle state=0, valid_cnt=0, rd_valid=0; re-arm and capture succeed.
- Back-to-back rd_en for 16 cycles in DONE -> 16 consecutive rd_valid pulses starting 2 cycles after first rd_en, data in order.
